// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the icache/dcache memory read arbiter.
// The line is fetched as a fixed four-beat burst.
package mem_read_arbiter_pkg;

    localparam int BURST_BEATS = 4;
    localparam int BEAT_W      = 32;
    localparam int LINE_W      = 128;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RESP
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_I) ? REQ_D : REQ_I;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_collector.sv
// Collects the beats of one read burst into a full line.
// Also flags bursts whose rlast does not line up with the fourth beat.
module rd_beat_collector #(
    parameter int BEAT_W = mem_read_arbiter_pkg::BEAT_W,
    parameter int LINE_W = mem_read_arbiter_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_en,
    input  logic [BEAT_W-1:0] beat_data,
    input  logic              beat_last,
    output logic [LINE_W-1:0] line,
    output logic              last_beat,
    output logic              rlast_err
);
    import mem_read_arbiter_pkg::*;

    localparam int CNT_W = $clog2(BURST_BEATS);

    logic [CNT_W-1:0] beat_cnt;

    // The counter wraps back to zero on the final beat, so every burst starts at slot 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt <= '0;
            line     <= '0;
        end else if (beat_en) begin
            line[beat_cnt*BEAT_W +: BEAT_W] <= beat_data;
            beat_cnt                         <= beat_cnt + 1'b1;
        end
    end

    assign last_beat = (beat_cnt == CNT_W'(BURST_BEATS - 1));
    assign rlast_err = beat_en && (beat_last != last_beat);

endmodule

// File: rtl/mem_read_arbiter.sv
// Arbitrates icache and dcache line reads onto one burst read port.
// Requests are granted alternately when both are pending.
module mem_read_arbiter #(
    parameter int ADDR_W = 32,
    parameter int BEAT_W = 32,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    output logic              i_rrdy,
    input  logic [3:0]        i_ren,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic              i_rvalid,
    output logic [LINE_W-1:0] i_rdata,
    output logic              d_rrdy,
    input  logic [3:0]        d_ren,
    input  logic [ADDR_W-1:0] d_raddr,
    output logic              d_rvalid,
    output logic [LINE_W-1:0] d_rdata,
    output logic              mem_arvalid,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic [7:0]        mem_arlen,
    input  logic              mem_arready,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    input  logic              mem_rlast,
    output logic              mem_rready,
    output logic              bus_err
);
    import mem_read_arbiter_pkg::*;

    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    arb_state_t        state_q, state_d;
    req_id_t           owner_q, last_grant_q, grant_id;
    logic              grant_en;
    logic              pending_i_q, pending_d_q;
    logic [ADDR_W-1:0] paddr_i_q, paddr_d_q;
    logic [LINE_W-1:0] hold_i_q, hold_d_q;
    logic              bus_err_q;
    logic              cap_i, cap_d, resp_i, resp_d, want_i, want_d;
    logic              beat_en, last_beat, rlast_err;
    logic [LINE_W-1:0] line;

    assign i_rrdy = !pending_i_q;
    assign d_rrdy = !pending_d_q;
    assign cap_i  = (|i_ren) && i_rrdy;
    assign cap_d  = (|d_ren) && d_rrdy;
    assign resp_i = (state_q == ST_RESP) && (owner_q == REQ_I);
    assign resp_d = (state_q == ST_RESP) && (owner_q == REQ_D);

    // A request being captured this cycle is eligible at once, which saves a cycle of latency;
    // the owner being answered is excluded so RESP can hand straight over to the other side.
    assign want_i = (pending_i_q && !resp_i) || cap_i;
    assign want_d = (pending_d_q && !resp_d) || cap_d;

    always_comb begin
        state_d  = state_q;
        grant_en = 1'b0;
        if (want_i && want_d) begin
            grant_id = other_req(last_grant_q);
        end else if (want_i) begin
            grant_id = REQ_I;
        end else begin
            grant_id = REQ_D;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (want_i || want_d) begin
                    state_d  = ST_AR;
                    grant_en = 1'b1;
                end
            end
            ST_AR: begin
                if (mem_arready) begin
                    state_d = ST_R;
                end
            end
            ST_R: begin
                if (beat_en && last_beat) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (want_i || want_d) begin
                    state_d  = ST_AR;
                    grant_en = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= REQ_D;
            last_grant_q <= REQ_D;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                owner_q      <= grant_id;
                last_grant_q <= grant_id;
            end
        end
    end

    // Pending flags and addresses only change while the port is ready, so the AR address stays stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_i_q <= 1'b0;
            pending_d_q <= 1'b0;
            paddr_i_q   <= '0;
            paddr_d_q   <= '0;
        end else begin
            if (cap_i) begin
                pending_i_q <= 1'b1;
                paddr_i_q   <= i_raddr & LINE_MASK;
            end else if (resp_i) begin
                pending_i_q <= 1'b0;
            end
            if (cap_d) begin
                pending_d_q <= 1'b1;
                paddr_d_q   <= d_raddr & LINE_MASK;
            end else if (resp_d) begin
                pending_d_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_i_q  <= '0;
            hold_d_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (resp_i) begin
                hold_i_q <= line;
            end
            if (resp_d) begin
                hold_d_q <= line;
            end
            if (rlast_err) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    rd_beat_collector #(
        .BEAT_W (BEAT_W),
        .LINE_W (LINE_W)
    ) u_collector (
        .clk       (clk),
        .rst       (rst),
        .beat_en   (beat_en),
        .beat_data (mem_rdata),
        .beat_last (mem_rlast),
        .line      (line),
        .last_beat (last_beat),
        .rlast_err (rlast_err)
    );

    assign beat_en     = mem_rvalid && mem_rready;
    assign mem_arvalid = (state_q == ST_AR);
    assign mem_araddr  = (owner_q == REQ_I) ? paddr_i_q : paddr_d_q;
    assign mem_arlen   = 8'(BURST_BEATS - 1);
    assign mem_rready  = (state_q == ST_R);
    assign i_rvalid    = resp_i;
    assign d_rvalid    = resp_d;
    assign i_rdata     = resp_i ? line : hold_i_q;
    assign d_rdata     = resp_d ? line : hold_d_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed-vector bench for mem_read_arbiter with a reactive memory model.
// Each scenario task drives traffic and compares against hand-computed values.
module tb_mem_read_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_rrdy, i_rvalid, d_rrdy, d_rvalid;
    logic [3:0]   i_ren, d_ren;
    logic [31:0]  i_raddr, d_raddr;
    logic [127:0] i_rdata, d_rdata;
    logic         mem_arvalid, mem_arready, mem_rvalid, mem_rlast, mem_rready, bus_err;
    logic [31:0]  mem_araddr, mem_rdata;
    logic [7:0]   mem_arlen;

    int          total = 0;
    int          bad = 0;
    logic [31:0] dat [8];
    logic [31:0] i_addr_g, d_addr_g;
    int          nar, ni, nd, i_cyc, d_cyc, i_beats, d_beats, arv_cnt, err_cyc;
    logic [31:0] ar_addr [8];
    int          ar_cyc [8];
    bit          ar_moved;
    logic [31:0] irdy_hist, drdy_hist;

    always #5 clk = ~clk;

    mem_read_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .i_rrdy      (i_rrdy),
        .i_ren       (i_ren),
        .i_raddr     (i_raddr),
        .i_rvalid    (i_rvalid),
        .i_rdata     (i_rdata),
        .d_rrdy      (d_rrdy),
        .d_ren       (d_ren),
        .d_raddr     (d_raddr),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .mem_arvalid (mem_arvalid),
        .mem_araddr  (mem_araddr),
        .mem_arlen   (mem_arlen),
        .mem_arready (mem_arready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .mem_rlast   (mem_rlast),
        .mem_rready  (mem_rready),
        .bus_err     (bus_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_ren       = 4'h0;
        d_ren       = 4'h0;
        i_raddr     = '0;
        d_raddr     = '0;
        mem_arready = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_rlast   = 1'b0;
    endtask

    // Drives requests at given cycles, answers bursts from dat[] and records what the DUT did.
    task automatic run_traffic(input int n_cyc, input int i_at, input int d_at,
                               input int ar_stall, input bit beat_gaps, input int bad_idx);
        int idx;
        int ar_run;
        bit acc;
        idx = 0; ar_run = 0; nar = 0; ni = 0; nd = 0; arv_cnt = 0;
        i_cyc = -1; d_cyc = -1; i_beats = -1; d_beats = -1; err_cyc = -1;
        ar_moved = 1'b0; irdy_hist = '0; drdy_hist = '0;
        for (int cyc = 0; cyc < n_cyc; cyc++) begin
            i_ren       = (cyc == i_at) ? 4'hF : 4'h0;
            i_raddr     = i_addr_g;
            d_ren       = (cyc == d_at) ? 4'h3 : 4'h0;
            d_raddr     = d_addr_g;
            mem_arready = mem_arvalid && (ar_run >= ar_stall);
            mem_rvalid  = beat_gaps ? (cyc % 2 == 1) : 1'b1;
            mem_rdata   = dat[idx & 7];
            mem_rlast   = (((idx & 3) == 3) != (idx == bad_idx));
            #1;
            if (cyc < 32) begin
                irdy_hist[cyc] = i_rrdy;
                drdy_hist[cyc] = d_rrdy;
            end
            if (mem_arvalid) begin
                arv_cnt++;
                if (ar_run == 0) begin
                    if (nar < 8) begin
                        ar_addr[nar] = mem_araddr;
                        ar_cyc[nar]  = cyc;
                    end
                    nar++;
                end else if (nar >= 1 && nar <= 8 && mem_araddr !== ar_addr[nar-1]) begin
                    ar_moved = 1'b1;
                end
                ar_run = mem_arready ? 0 : ar_run + 1;
            end
            if (i_rvalid) begin
                ni++;
                i_cyc   = cyc;
                i_beats = idx;
            end
            if (d_rvalid) begin
                nd++;
                d_cyc   = cyc;
                d_beats = idx;
            end
            if (bus_err && err_cyc < 0) err_cyc = cyc;
            acc = mem_rvalid && mem_rready;
            tick();
            if (acc) idx++;
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #3;
        total++;
        if ({i_rrdy, d_rrdy, i_rvalid, d_rvalid, mem_arvalid, mem_rready, bus_err} !== 7'b1100000) begin
            bad++;
            $display("[TB] FAIL reset_flags got=%b exp=%b",
                     {i_rrdy, d_rrdy, i_rvalid, d_rvalid, mem_arvalid, mem_rready, bus_err}, 7'b1100000);
        end
        total++;
        if ({i_rdata, d_rdata} !== 256'h0) begin
            bad++;
            $display("[TB] FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata});
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        total++;
        if ({i_rrdy, d_rrdy, mem_arvalid, mem_rready} !== 4'b1100) begin
            bad++;
            $display("[TB] FAIL after_reset_flags got=%b exp=%b", {i_rrdy, d_rrdy, mem_arvalid, mem_rready}, 4'b1100);
        end
        total++;
        if (mem_arlen !== 8'd3) begin
            bad++;
            $display("[TB] FAIL arlen got=%0d exp=3", mem_arlen);
        end
    endtask

    task automatic test_single_icache();
        dat[0] = 32'h11111111; dat[1] = 32'h22222222; dat[2] = 32'h33333333; dat[3] = 32'h44444444;
        for (int k = 4; k < 8; k++) dat[k] = 32'hEEEE_0000 + 32'(k);
        i_addr_g = 32'h1C00_0124;
        d_addr_g = 32'h0;
        run_traffic(9, 0, -1, 0, 1'b0, -1);
        total++;
        if (nar !== 1 || ar_cyc[0] !== 1 || ar_addr[0] !== 32'h1C00_0120) begin
            bad++;
            $display("[TB] FAIL single_ar got n=%0d cyc=%0d addr=%h exp n=1 cyc=1 addr=1c000120", nar, ar_cyc[0], ar_addr[0]);
        end
        total++;
        if (ni !== 1 || i_cyc !== 6 || nd !== 0) begin
            bad++;
            $display("[TB] FAIL single_rvalid got ni=%0d cyc=%0d nd=%0d exp ni=1 cyc=6 nd=0", ni, i_cyc, nd);
        end
        total++;
        if (i_rdata !== 128'h44444444_33333333_22222222_11111111) begin
            bad++;
            $display("[TB] FAIL single_rdata got=%h exp=%h", i_rdata, 128'h44444444_33333333_22222222_11111111);
        end
        total++;
        if (irdy_hist[1] !== 1'b0 || irdy_hist[6] !== 1'b0 || irdy_hist[7] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_rrdy got c1=%b c6=%b c7=%b exp c1=0 c6=0 c7=1", irdy_hist[1], irdy_hist[6], irdy_hist[7]);
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) dat[k] = 32'hA0A0_0000 + 32'(k * 17);
        i_addr_g = 32'h0000_1000;
        d_addr_g = 32'h0000_2008;
        run_traffic(16, 0, 0, 0, 1'b0, -1);
        total++;
        if (nar !== 2 || ar_addr[0] !== 32'h0000_1000 || ar_addr[1] !== 32'h0000_2000) begin
            bad++;
            $display("[TB] FAIL simul_order got n=%0d a0=%h a1=%h exp n=2 a0=00001000 a1=00002000", nar, ar_addr[0], ar_addr[1]);
        end
        total++;
        if (ni !== 1 || nd !== 1 || i_cyc !== 6 || d_cyc !== 12) begin
            bad++;
            $display("[TB] FAIL simul_rvalid got ni=%0d nd=%0d ic=%0d dc=%0d exp 1 1 6 12", ni, nd, i_cyc, d_cyc);
        end
        total++;
        if (i_rdata !== {dat[3], dat[2], dat[1], dat[0]} || d_rdata !== {dat[7], dat[6], dat[5], dat[4]}) begin
            bad++;
            $display("[TB] FAIL simul_rdata got i=%h d=%h exp i=%h d=%h", i_rdata, d_rdata,
                     {dat[3], dat[2], dat[1], dat[0]}, {dat[7], dat[6], dat[5], dat[4]});
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) dat[k] = 32'h5150_0000 + 32'(k * 3);
        i_addr_g = 32'h0000_401C;
        d_addr_g = 32'h3000_0047;
        run_traffic(16, 0, 3, 0, 1'b0, -1);
        total++;
        if (drdy_hist[3] !== 1'b1 || drdy_hist[4] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_d_rrdy got c3=%b c4=%b exp c3=1 c4=0", drdy_hist[3], drdy_hist[4]);
        end
        total++;
        if (nar !== 2 || ar_cyc[1] !== 7 || ar_addr[0] !== 32'h0000_4010 || ar_addr[1] !== 32'h3000_0040) begin
            bad++;
            $display("[TB] FAIL b2b_ar got n=%0d c1=%0d a0=%h a1=%h exp 2 7 00004010 30000040", nar, ar_cyc[1], ar_addr[0], ar_addr[1]);
        end
        total++;
        if (i_cyc !== 6 || d_cyc !== 12 || ni !== 1 || nd !== 1) begin
            bad++;
            $display("[TB] FAIL b2b_rvalid got ic=%0d dc=%0d ni=%0d nd=%0d exp 6 12 1 1", i_cyc, d_cyc, ni, nd);
        end
        total++;
        if (d_rdata !== {dat[7], dat[6], dat[5], dat[4]} || i_rdata !== {dat[3], dat[2], dat[1], dat[0]}) begin
            bad++;
            $display("[TB] FAIL b2b_rdata got i=%h d=%h exp i=%h d=%h", i_rdata, d_rdata,
                     {dat[3], dat[2], dat[1], dat[0]}, {dat[7], dat[6], dat[5], dat[4]});
        end
    endtask

    task automatic test_stalls();
        for (int k = 0; k < 8; k++) dat[k] = 32'hC0DE_0000 + 32'(k * 257);
        i_addr_g = 32'h0000_050C;
        d_addr_g = 32'h0;
        run_traffic(18, 0, -1, 5, 1'b1, -1);
        total++;
        if (ar_moved !== 1'b0 || nar !== 1 || arv_cnt !== 6 || ar_addr[0] !== 32'h0000_0500) begin
            bad++;
            $display("[TB] FAIL stall_ar got moved=%b n=%0d len=%0d addr=%h exp 0 1 6 00000500", ar_moved, nar, arv_cnt, ar_addr[0]);
        end
        total++;
        if (ni !== 1 || i_cyc !== 14 || i_beats !== 4) begin
            bad++;
            $display("[TB] FAIL stall_rvalid got ni=%0d cyc=%0d beats=%0d exp 1 14 4", ni, i_cyc, i_beats);
        end
        total++;
        if (i_rdata !== {dat[3], dat[2], dat[1], dat[0]}) begin
            bad++;
            $display("[TB] FAIL stall_rdata got=%h exp=%h", i_rdata, {dat[3], dat[2], dat[1], dat[0]});
        end
    endtask

    task automatic test_rlast_err();
        total++;
        if (bus_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL err_before got=%b exp=0", bus_err);
        end
        for (int k = 0; k < 8; k++) dat[k] = 32'h7700_0000 + 32'(k * 5);
        i_addr_g = 32'h0000_0830;
        run_traffic(10, 0, -1, 0, 1'b0, 1);
        total++;
        if (err_cyc !== 4) begin
            bad++;
            $display("[TB] FAIL err_rise got cyc=%0d exp=4", err_cyc);
        end
        total++;
        if (ni !== 1 || i_cyc !== 6 || i_rdata !== {dat[3], dat[2], dat[1], dat[0]}) begin
            bad++;
            $display("[TB] FAIL err_resp got ni=%0d cyc=%0d data=%h exp 1 6 %h", ni, i_cyc, i_rdata, {dat[3], dat[2], dat[1], dat[0]});
        end
        tick();
        tick();
        tick();
        total++;
        if (bus_err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL err_sticky got=%b exp=1", bus_err);
        end
    endtask

    task automatic test_reset_midburst();
        int stray;
        for (int k = 0; k < 8; k++) dat[k] = 32'h9100_0000 + 32'(k * 11);
        i_ren       = 4'h1;
        i_raddr     = 32'h5000_0000;
        mem_arready = 1'b1;
        mem_rvalid  = 1'b1;
        mem_rdata   = dat[0];
        tick();
        i_ren = 4'h0;
        tick();
        tick();
        mem_rdata = dat[1];
        rst = 1'b0;
        #1;
        total++;
        if ({i_rrdy, d_rrdy, i_rvalid, mem_arvalid, mem_rready, bus_err} !== 6'b110000) begin
            bad++;
            $display("[TB] FAIL midrst_flags got=%b exp=%b", {i_rrdy, d_rrdy, i_rvalid, mem_arvalid, mem_rready, bus_err}, 6'b110000);
        end
        total++;
        if ({i_rdata, d_rdata} !== 256'h0) begin
            bad++;
            $display("[TB] FAIL midrst_rdata got=%h exp=0", {i_rdata, d_rdata});
        end
        tick();
        tick();
        rst = 1'b1;
        idle_inputs();
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (i_rvalid || d_rvalid || mem_arvalid) stray++;
        end
        total++;
        if (stray !== 0) begin
            bad++;
            $display("[TB] FAIL midrst_stray got=%0d exp=0", stray);
        end
        i_addr_g = 32'h5000_0000;
        run_traffic(9, 0, -1, 0, 1'b0, -1);
        total++;
        if (ni !== 1 || i_cyc !== 6 || i_rdata !== {dat[3], dat[2], dat[1], dat[0]} || bus_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midrst_next got ni=%0d cyc=%0d data=%h err=%b exp 1 6 %h 0",
                     ni, i_cyc, i_rdata, bus_err, {dat[3], dat[2], dat[1], dat[0]});
        end
    endtask

    initial begin
        test_reset();
        test_single_icache();
        test_simultaneous();
        test_back_to_back();
        test_stalls();
        test_rlast_err();
        test_reset_midburst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width.
REQ-002 Parameter BEAT_W, 32, memory data beat width.
REQ-003 Parameter LINE_W, 128, cache line width; LINE_W/BEAT_W = 4 beats per line.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 i_rrdy  out  1  arbiter can accept an icache line read.
REQ-007 i_ren  in  4  icache read enable; any nonzero value is a request.
REQ-008 i_raddr  in  ADDR_W  icache line address.
REQ-009 i_rvalid  out  1  one-cycle pulse: icache line returned.
REQ-010 i_rdata  out  LINE_W  icache line data.
REQ-011 d_rrdy / d_ren / d_raddr / d_rvalid / d_rdata: the same directions, widths and meanings for the dcache.
REQ-012 mem_arvalid  out  1  read-address valid.
REQ-013 mem_araddr  out  ADDR_W  line-aligned burst address.
REQ-014 mem_arlen  out  8  burst length minus one; constant 3.
REQ-015 mem_arready  in  1  address accepted.
REQ-016 mem_rvalid  in  1  read beat valid.
REQ-017 mem_rdata  in  BEAT_W  read beat data.
REQ-018 mem_rlast  in  1  last beat of burst.
REQ-019 mem_rready  out  1  beat accept.
REQ-020 bus_err  out  1  sticky protocol-error flag.

Function
REQ-021 Capture: on a cycle with x_ren != 0 and x_rrdy = 1, latch pending_x = 1 and paddr_x = {x_raddr[31:4], 4'b0}; a request made while x_rrdy = 0 is ignored.
REQ-022 x_rrdy = !pending_x (combinational); it rises in the cycle after that requester's x_rvalid pulse.
REQ-023 FSM states: IDLE, AR, R, RESP.
REQ-024 IDLE: if any pending_x is set, grant one requester and go to AR on the next edge; the grant is held until RESP ends.
REQ-025 Arbitration: if one requester is pending, grant it; if both are pending, grant the requester not recorded in last_grant; update last_grant on each grant.
REQ-026 AR: mem_arvalid = 1 and mem_araddr = paddr of the owner; go to R on mem_arready.
REQ-027 R: mem_rready = 1; each beat accepted (mem_rvalid & mem_rready) is stored at line[32*k +: 32], where k is a 2-bit beat counter starting at 0.
REQ-028 R ends on the 4th accepted beat; go to RESP.
REQ-029 mem_rlast mismatch: if mem_rlast = 1 with k != 3, or mem_rlast = 0 with k = 3, set bus_err sticky; completion still occurs on the 4th beat.
REQ-030 RESP: for one cycle, pulse owner_rvalid = 1 with owner_rdata = the assembled line, clear pending_owner, return to IDLE.
REQ-031 x_rdata holds its value until the next response to x; the non-owner's rvalid stays 0.
REQ-032 Latency with no contention and arready/rvalid tied high: capture at cycle N, arvalid at N+1, beats at N+2 to N+5, rvalid at N+6.
REQ-033 While the other requester is being served, a new request is captured (REQ-021) and served next.
REQ-034 mem_arvalid, once raised, stays high with a stable address until accepted.

Reset
REQ-035 Asynchronous reset drives: state to IDLE, pending_i/pending_d to 0, last_grant to D, beat counter to 0, line to 0, bus_err to 0.
REQ-036 Output values during and after reset: all rvalid = 0, rdata = 0, mem_arvalid = 0, mem_rready = 0, i_rrdy = d_rrdy = 1.
REQ-037 Reset in mid-burst discards the transaction; no rvalid pulse is issued for it.

Structure
REQ-038 Shared package: FSM state enum, BURST_BEATS = 4, LINE_W, BEAT_W, requester-ID type (REQ_I, REQ_D).
REQ-039 One sub-module, rd_beat_collector, contains the beat counter, line assembly register and rlast check.

Verification
REQ-040 Single icache read: i_ren=4'hF, i_raddr=32'h1C00_0124, memory returns beats 11111111, 22222222, 33333333, 44444444 -> mem_araddr=32'h1C00_0120, arlen=3, i_rvalid pulses at N+6, i_rdata=128'h44444444_33333333_22222222_11111111.
REQ-041 Simultaneous i/d requests after reset -> icache granted first, dcache second; each rvalid pulses exactly once, to the correct port.
REQ-042 Back-to-back: a dcache request arrives during an icache burst -> captured, d_rrdy=0, dcache AR issued in the cycle after i_rvalid.
REQ-043 Stalled handshakes: arready held low 5 cycles, gaps between beats -> araddr stays stable, line assembled correctly, no early rvalid.
REQ-044 mem_rlast asserted on beat 2 -> bus_err=1 and stays 1; response still follows the 4th beat.
REQ-045 rst asserted low during beat 2 -> outputs take reset values immediately; the next request completes normally.
